// File: rtl/muxn_pkg.sv
// Shared types and helpers for the muxn_pipe operand select stage.
// The beat struct is shared by the output register and the optional skid entry.
package muxn_pkg;

  localparam int MUXN_MAX_IN = 16;
  localparam int MUXN_SEL_W  = $clog2(MUXN_MAX_IN);
  // Data width carried by a beat; muxn_pipe WIDTH must match it.
  localparam int MUXN_DATA_W = 32;

  typedef struct packed {
    logic [MUXN_DATA_W-1:0] data;
    logic                   err;
  } muxn_beat_t;

  function automatic logic muxn_sel_legal(input logic [MUXN_SEL_W-1:0] sel, input int num_in);
    return int'(sel) < num_in;
  endfunction

endpackage

// File: rtl/muxn_pipe_if.sv
// Valid/ready bus of the muxn_pipe operand select stage.
// master drives beats in and accepts results; slave is the select stage.
interface muxn_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 4,
  parameter int SEL_W     = $clog2(NUM_IN),
  parameter int ERR_CNT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] d;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        y;
  logic                    sel_err;
  logic [ERR_CNT_W-1:0]    err_count;

  modport master (
    output in_valid, sel, d, out_ready,
    input  in_ready, out_valid, y, sel_err, err_count
  );

  modport slave (
    input  in_valid, sel, d, out_ready,
    output in_ready, out_valid, y, sel_err, err_count
  );
endinterface

// File: rtl/muxn_skid_buf.sv
// 1-entry skid buffer: output register plus one spare entry, so that
// s_ready is registered and independent of m_ready.
module muxn_skid_buf
  import muxn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  muxn_beat_t s_beat,
  output logic       m_valid,
  input  logic       m_ready,
  output muxn_beat_t m_beat
);
  logic       skid_valid;
  muxn_beat_t skid_beat;
  logic       accept;

  assign s_ready = !skid_valid;
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_beat     <= '0;
      skid_valid <= 1'b0;
    end else if (!m_valid || m_ready) begin
      // A full skid entry blocks s_ready, so it never competes with accept.
      if (skid_valid) begin
        m_beat     <= skid_beat;
        m_valid    <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        m_beat  <= s_beat;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: the skid payload has no reset; skid_valid qualifies it, so its contents never leak.
  always_ff @(posedge clk) begin
    if (m_valid && !m_ready && accept) begin
      skid_beat <= s_beat;
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// N-way registered operand select with valid/ready, illegal-select handling and
// a saturating error counter. Define MUXN_PIPE_SKID_EN for a registered in_ready.
module muxn_pipe
  import muxn_pkg::*;
#(
  parameter int WIDTH     = MUXN_DATA_W,
  parameter int NUM_IN    = 4,
  parameter int SEL_W     = $clog2(NUM_IN),
  parameter int ERR_CNT_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  muxn_pipe_if.slave bus
);
  logic                 sel_legal;
  logic [WIDTH-1:0]     sel_data;
  logic                 accept;
  muxn_beat_t           new_beat;
  muxn_beat_t           out_beat;
  logic                 out_valid_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  assign sel_legal = muxn_sel_legal(MUXN_SEL_W'(bus.sel), NUM_IN);

  // NOTE: default first so no path through always_comb leaves sel_data unassigned (no latch).
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SEL_W'(i) == bus.sel) begin
        sel_data = bus.d[i*WIDTH +: WIDTH];
      end
    end
  end

  // An illegal select matches no source, so its data is already zero.
  assign new_beat.data = sel_data;
  assign new_beat.err  = !sel_legal;
  assign accept        = bus.in_valid && bus.in_ready;

`ifdef MUXN_PIPE_SKID_EN
  logic skid_ready;

  muxn_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (bus.in_valid),
    .s_ready (skid_ready),
    .s_beat  (new_beat),
    .m_valid (out_valid_q),
    .m_ready (bus.out_ready),
    .m_beat  (out_beat)
  );

  assign bus.in_ready = skid_ready;
`else
  assign bus.in_ready = !out_valid_q || bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_beat    <= '0;
    end else if (accept) begin
      out_beat    <= new_beat;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (accept && new_beat.err && (err_count_q != '1)) begin
      err_count_q <= err_count_q + ERR_CNT_W'(1);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = out_beat.data;
  assign bus.sel_err   = out_beat.err;
  assign bus.err_count = err_count_q;

endmodule

// File: doc/muxn_pipe.md
Name: muxn_pipe

Overview:
Parametrised N-way operand select stage for the pipelined RSA CPU datapath. It generalises the combinational 3-input forwarding mux in three ways: a registered output with a valid/ready handshake, defined handling of illegal selects, and an error counter.
It sits between the forwarding-select logic and the EX stage operand latch, so a stalled EX holds the selected operand without re-evaluating the sources.

Parameters:
- WIDTH, 32, data width of each source and of the output.
- NUM_IN, 4, number of data sources; legal range 2..16.
- SEL_W, $clog2(NUM_IN), select width; derived, do not override.
- ERR_CNT_W, 8, width of the saturating illegal-select counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- sel  in  SEL_W  source index; sampled with the beat.
- d  in  NUM_IN*WIDTH  sources, flattened; source i occupies d[i*WIDTH +: WIDTH].
- out_valid  out  1  y holds a valid beat.
- out_ready  in  1  downstream accepts the beat.
- y  out  WIDTH  selected data, registered.
- sel_err  out  1  held beat was produced from an illegal select.
- err_count  out  ERR_CNT_W  saturating count of accepted illegal-select beats.

Behaviour:
- Reset is asynchronous on the falling edge of rst_n and releases synchronously to clk.
  - Reset values: out_valid=0, y=0, sel_err=0, err_count=0.
  - in_ready=1 (combinational, follows from out_valid=0).
- Handshake:
  - Accept when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - in_ready = !out_valid || out_ready, combinational.
- Latency: 1 cycle. A beat accepted at edge k appears on y with out_valid=1 after edge k.
- Legal select (sel < NUM_IN): y <= source sel on accept.
- Illegal select (sel >= NUM_IN): y <= 0, never X, and sel_err <= 1 for that beat. This only applies when NUM_IN is not a power of two.
- sel_err is registered alongside y and cleared by the next accepted legal beat.
- Error counter:
  - err_count increments by 1 on each accepted illegal beat.
  - It saturates at all-ones and does not wrap.
- Stall: out_valid && !out_ready holds y, sel_err and out_valid; in_ready=0; d and sel are ignored.
- Simultaneous transfer-out and accept in one cycle: the new beat replaces the old one. No bubble; out_valid stays 1.
- Drain: transfer-out with no accept sets out_valid <= 0. y keeps its last value.
- Reset mid-stall: the held beat is discarded and err_count clears.
- There is no flush input; flush is done by reset only.
- in_valid=0 never changes y.

Optional Feature:
- Macro MUXN_PIPE_SKID_EN.
- Defined: a 1-entry skid buffer is inserted so that in_ready is a registered signal. in_ready depends only on internal state, not on out_ready, which breaks the combinational ready path for timing.
  - in_ready=1 exactly when the skid entry is empty.
  - A beat arriving while the output stalls is captured in the skid entry.
  - The skid entry drains to the output on the next out_ready.
  - Throughput remains 1 beat/cycle; latency remains 1 cycle when not stalled.
  - Illegal selects are resolved (y=0, sel_err set, counter bumped) at accept time, before the beat enters skid or output.
  - Reset empties the skid entry.
- Undefined: behaviour exactly as in Behaviour, with combinational in_ready.

Decomposition:
- Package muxn_pkg holds:
  - localparam MUXN_MAX_IN=16.
  - Function muxn_sel_legal(sel, num_in).
  - Typedef muxn_beat_t: struct of data[WIDTH] and err bit, used for both the output register and the skid entry.
- One natural sub-module: muxn_skid_buf, a 1-entry valid/ready register slice. It is instantiated only under MUXN_PIPE_SKID_EN.
- Selection logic stays inline in muxn_pipe.

Test Plan:
- Reset then idle: after rst_n rises, out_valid=0, y=0, err_count=0, in_ready=1.
- Streaming: NUM_IN=4 with d0..d3 = 0x10,0x20,0x30,0x40, sel sequence 3,0,2,1 back-to-back, out_ready=1. Required: y = 0x40,0x10,0x30,0x20 on consecutive cycles, one cycle after each accept, with no bubbles.
- Backpressure: hold out_ready=0 for 3 cycles while y=0x30. Required: y holds 0x30, in_ready=0, and a new in_valid beat is not accepted. Then assert out_ready with a new beat (sel=0): y=0x10 next cycle.
- Illegal select: NUM_IN=3, sel=3.
  - Required: y=0, sel_err=1, err_count=1.
  - A following sel=1 beat gives sel_err=0 and err_count stays at 1.
  - 300 illegal beats with ERR_CNT_W=8 leave err_count at 255.
- Async reset mid-stall: assert rst_n=0 between edges while out_valid=1 and out_ready=0. Required: out_valid and y drop to 0 immediately, before the next clock edge.
- Skid build (MUXN_PIPE_SKID_EN): stall the output and offer 2 beats. Required: the first is held in the output register and the second is captured in the skid entry, after which in_ready=0. Releasing out_ready then delivers both beats in order on consecutive cycles.
